// File: rtl/lsu_pkg.sv
// Shared types and default constants for the LSU stack controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam logic [14:0]  SP_TOP_DEF = 15'h7FFF;
    localparam int unsigned  DEPTH_DEF  = 256;

    typedef struct packed {
        logic req;
        logic we;
    } mem_cmd_t;

endpackage

// File: rtl/lsu_sp_reg.sv
// Stack pointer register with inc/dec enables and a one-cycle-delayed debug copy.
module lsu_sp_reg
    import lsu_pkg::*;
#(
    parameter int unsigned     SP_W   = 15,
    parameter logic [SP_W-1:0] SP_TOP = SP_TOP_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [SP_W-1:0] sp_o,
    output logic [SP_W:0]   sp_dbg_o
);

    logic [SP_W-1:0] ptr_q, ptr_d;
    logic [SP_W:0]   dbg_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + SP_W'(1);
        end else if (dec_i) begin
            ptr_d = ptr_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= SP_TOP;
            dbg_q <= {1'b0, SP_TOP};
        end else begin
            ptr_q <= ptr_d;
            dbg_q <= {1'b0, ptr_q};
        end
    end

    assign sp_o     = ptr_q;
    assign sp_dbg_o = dbg_q;

endmodule

// File: rtl/lsu_stack_ctrl.sv
// Push/pop sequencer: one op per handshake, runs the memory access, returns pop data.
// Optional overflow/underflow guard enabled by `LSU_STACK_GUARD_EN.
module lsu_stack_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned     DATA_W = 8,
    parameter int unsigned     SP_W   = 15,
    parameter logic [SP_W-1:0] SP_TOP = SP_TOP_DEF,
    parameter int unsigned     DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_push,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              op_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [SP_W:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [SP_W:0]     sp_q
);

    localparam logic [SP_W-1:0] SP_FULL = SP_TOP - SP_W'(DEPTH);

    lsu_state_e      state_q;
    mem_cmd_t        cmd_q;
    logic            push_q;
    logic            err_q;
    logic            guard_hit;
    logic            ack_fire;
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_above;

    assign sp_above = sp + SP_W'(1);
    assign ack_fire = (state_q == ACCESS) && mem_ack;

`ifdef LSU_STACK_GUARD_EN
    assign guard_hit = op_push ? (sp == SP_FULL) : (sp == SP_TOP);
`else
    logic unused_full;
    assign unused_full = ^SP_FULL;
    assign guard_hit   = 1'b0;
`endif

    lsu_sp_reg #(
        .SP_W   (SP_W),
        .SP_TOP (SP_TOP)
    ) u_sp_reg (
        .clk_i    (clk),
        .rst_i    (rst),
        .inc_i    (ack_fire && !push_q),
        .dec_i    (ack_fire && push_q),
        .sp_o     (sp),
        .sp_dbg_o (sp_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            push_q    <= 1'b0;
            err_q     <= 1'b0;
            op_ready  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        push_q   <= op_push;
                        err_q    <= guard_hit;
                        op_ready <= 1'b0;
                        // A guarded error skips the memory phase entirely.
                        if (guard_hit) begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state_q   <= ACCESS;
                            cmd_q     <= '{req: 1'b1, we: op_push};
                            mem_addr  <= {1'b0, op_push ? sp : sp_above};
                            mem_wdata <= op_push ? op_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state_q   <= RESP;
                        cmd_q     <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= push_q ? '0 : mem_rdata;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    cmd_q    <= '0;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

    assign mem_req = cmd_q.req;
    assign mem_we  = cmd_q.we;
    assign rsp_err = err_q;

endmodule

// File: tb/tb_lsu_stack_ctrl.sv
// Bench for lsu_stack_ctrl: queue-based stack model, memory responder, per-cycle monitor.
module tb_lsu_stack_ctrl;

    localparam logic [14:0] TOP   = 15'h7FFF;
    localparam int          DEPTH = 256;
`ifdef LSU_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_push = 1'b0;
    logic [7:0]  op_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        op_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [7:0]  rsp_rdata, mem_wdata;
    logic [15:0] mem_addr, sp_q;

    always #5 clk = ~clk;

    lsu_stack_ctrl #(
        .DATA_W (8),
        .SP_W   (15),
        .SP_TOP (TOP),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_push   (op_push),
        .op_wdata  (op_wdata),
        .op_ready  (op_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .sp_q      (sp_q)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue holds stacked words; m_sp is the pointer the spec defines.
    logic [7:0]  stk[$];
    logic [14:0] m_sp = TOP;
    logic [15:0] exp_addr = '0;
    logic [15:0] exp_spq = {1'b0, TOP};
    logic [7:0]  exp_wdata = '0;
    logic [7:0]  exp_rdata = '0;
    logic        exp_we = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_mem = 1'b0;
    logic        rsp_pend = 1'b0;

    logic [15:0] last_addr = '0;
    logic [7:0]  last_rdata = '0;
    logic        last_err = 1'b0;
    logic        req_seen = 1'b0;
    int          rsp_cnt = 0;

    // Memory responder; unwritten locations read back 0xEE.
    logic [7:0] mem [int];
    int         ack_dly = 0;
    int         ack_cnt = 0;
    logic       stray = 1'b0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (ack_cnt >= ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'hEE;
                if (mem_we) mem[int'(mem_addr)] = mem_wdata;
                ack_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            mem_ack = stray;
            ack_cnt = 0;
        end
    end

    logic prev_rsp = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_rsp = 1'b0;
        end else begin
            if (mem_req) begin
                chk("req_expected", mem_req, exp_mem);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", mem_we, exp_we);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
                chk("ready_in_access", op_ready, 1'b0);
                last_addr = mem_addr;
                req_seen  = 1'b1;
            end
            if (rsp_valid) begin
                chk("rsp_expected", rsp_valid, rsp_pend);
                chk("rsp_single_cycle", prev_rsp, 1'b0);
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", rsp_err, exp_err);
                chk("ready_in_resp", op_ready, 1'b0);
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                rsp_cnt++;
            end else if (op_ready) begin
                chk("sp_q_idle", sp_q, exp_spq);
            end
            prev_rsp = rsp_valid;
        end
    end

    task automatic model_reset();
        stk.delete();
        m_sp     = TOP;
        exp_spq  = {1'b0, TOP};
        exp_mem  = 1'b0;
        rsp_pend = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_op(input bit push, input logic [7:0] d, input int dly, input bit noise);
        bit err;
        int waited;
        @(negedge clk);
        chk("ready_before_op", op_ready, 1'b1);
        err       = GUARD && (push ? (stk.size() == DEPTH) : (stk.size() == 0));
        exp_mem   = !err;
        exp_we    = push;
        exp_wdata = d;
        exp_err   = err;
        exp_addr  = {1'b0, push ? m_sp : m_sp + 15'd1};
        exp_rdata = (push || err) ? 8'h00 : ((stk.size() == 0) ? 8'hEE : stk[$]);
        rsp_pend  = 1'b1;
        req_seen  = 1'b0;
        ack_dly   = dly;
        op_valid  = 1'b1;
        op_push   = push;
        op_wdata  = d;
        @(negedge clk);
        op_valid = 1'b0;
        chk("req_after_accept", mem_req, !err);
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            if (noise) begin
                op_valid = 1'b1;
                op_push  = 1'($urandom_range(0, 1));
                op_wdata = 8'($urandom);
            end
            @(negedge clk);
            waited++;
        end
        op_valid = 1'b0;
        chk("rsp_latency", waited, err ? 0 : dly + 1);
        rsp_pend = 1'b0;
        if (!err) begin
            if (push) begin
                stk.push_back(d);
                m_sp = m_sp - 15'd1;
            end else begin
                if (stk.size() > 0) void'(stk.pop_back());
                m_sp = m_sp + 15'd1;
            end
        end
        exp_spq = {1'b0, m_sp};
        exp_mem = 1'b0;
        chk("req_seen", req_seen, !err);
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_sp_q", sp_q, 16'h7FFF);
        rst = 1'b0;

        c0 = rsp_cnt;
        do_op(1'b1, 8'hA5, 2, 1'b0);
        chk("t1_addr", last_addr, 16'h7FFF);
        @(negedge clk);
        chk("t1_rsp_pulses", rsp_cnt - c0, 1);
        chk("t1_sp_q", sp_q, 16'h7FFE);

        do_reset();
        do_op(1'b1, 8'h11, 1, 1'b0);
        do_op(1'b1, 8'h22, 0, 1'b0);
        do_op(1'b0, 8'h00, 3, 1'b0);
        chk("t2_pop1_addr", last_addr, 16'h7FFE);
        chk("t2_pop1_data", last_rdata, 8'h22);
        do_op(1'b0, 8'h00, 0, 1'b0);
        chk("t2_pop2_addr", last_addr, 16'h7FFF);
        chk("t2_pop2_data", last_rdata, 8'h11);
        @(negedge clk);
        chk("t2_sp_q", sp_q, 16'h7FFF);

        c0 = rsp_cnt;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_ack_no_rsp", rsp_cnt, c0);
        chk("stray_ack_sp_q", sp_q, 16'h7FFF);

        do_op(1'b1, 8'h3C, 10, 1'b1);
        chk("t4_addr", last_addr, 16'h7FFF);
        do_op(1'b0, 8'h00, 0, 1'b0);
        chk("t4_pop_data", last_rdata, 8'h3C);

        do_op(1'b0, 8'h00, 1, 1'b0);
        @(negedge clk);
`ifdef LSU_STACK_GUARD_EN
        chk("t5_err", last_err, 1'b1);
        chk("t5_rdata", last_rdata, 8'h00);
        chk("t5_sp_q", sp_q, 16'h7FFF);
`else
        chk("t5_addr", last_addr, 16'h0000);
        chk("t5_rdata", last_rdata, 8'hEE);
        chk("t5_sp_q", sp_q, 16'h0000);
`endif

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1'b1, 8'(i) ^ 8'h5A, 0, 1'b0);
        end
        @(negedge clk);
        chk("t6_full_sp_q", sp_q, 16'h7EFF);
        do_op(1'b1, 8'hF0, 0, 1'b0);
        @(negedge clk);
`ifdef LSU_STACK_GUARD_EN
        chk("t6_over_err", last_err, 1'b1);
        chk("t6_over_sp_q", sp_q, 16'h7EFF);
`else
        chk("t6_over_addr", last_addr, 16'h7EFF);
        chk("t6_over_sp_q", sp_q, 16'h7EFE);
`endif
        do_op(1'b0, 8'h00, 1, 1'b0);

        do_reset();
        @(negedge clk);
        exp_mem   = 1'b1;
        exp_we    = 1'b1;
        exp_wdata = 8'h77;
        exp_addr  = {1'b0, m_sp};
        rsp_pend  = 1'b0;
        ack_dly   = 1000;
        op_valid  = 1'b1;
        op_push   = 1'b1;
        op_wdata  = 8'h77;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7_req_before_rst", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t7_req_drop", mem_req, 1'b0);
        chk("t7_ready", op_ready, 1'b1);
        chk("t7_sp_q", sp_q, 16'h7FFF);
        c0 = rsp_cnt;
        @(negedge clk);
        rst = 1'b0;
        ack_dly = 0;
        repeat (3) @(negedge clk);
        chk("t7_no_rsp", rsp_cnt, c0);
        chk("t7_sp_q_after", sp_q, 16'h7FFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
